// File: rtl/mac_row_seq.sv
// Issue sequencer for one mac_row pass: walks taps within output pixels, strobes the
// buffer reads, and tracks the MAC pipeline so it can flag finished pixel sums.
module mac_row_seq #(
    parameter int TW      = 5,
    parameter int PW      = 10,
    parameter int MAC_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [TW-1:0] cfg_taps,
    input  logic [PW-1:0] cfg_pix,
    input  logic          in_valid,
    output logic          rd_en,
    output logic [TW-1:0] tap_idx,
    output logic [PW-1:0] pix_idx,
    output logic          w_en,
    output logic          acc_clr,
    output logic          out_valid,
    output logic [PW-1:0] out_pix,
    output logic          busy,
    output logic          done,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [TW-1:0]      TAP_ONE  = 1;
    localparam logic [PW-1:0]      PIX_ONE  = 1;
    // Every stage of the result shift register except the one driving out_valid.
    localparam logic [MAC_LAT-1:0] LOW_MASK = {MAC_LAT{1'b1}} >> 1;

    state_t        state, state_nxt;
    logic [TW-1:0] taps_q;
    logic [PW-1:0] pix_q;
    logic          w_last;
    logic [PW-1:0] w_pix;
    logic [MAC_LAT-1:0] ov_sr;
    logic [PW-1:0]      pix_sr [MAC_LAT];

    logic issue, last_tap, last_pix, final_issue, pipe_drained;

    assign last_tap     = (tap_idx == taps_q - TAP_ONE);
    assign last_pix     = (pix_idx == pix_q - PIX_ONE);
    assign issue        = (state == RUN) && in_valid;
    assign final_issue  = issue && last_tap && last_pix;
    // True when nothing will remain in flight after this cycle.
    assign pipe_drained = !w_en && ((ov_sr & LOW_MASK) == '0);

    assign out_valid = ov_sr[MAC_LAT-1];
    assign out_pix   = pix_sr[MAC_LAT-1];
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_taps == '0 || cfg_pix == '0) state_nxt = DONE;
                    else                                 state_nxt = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                rd_en = in_valid;
                if (final_issue) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pipe_drained) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            taps_q  <= '0;
            pix_q   <= '0;
            tap_idx <= '0;
            pix_idx <= '0;
            w_en    <= 1'b0;
            acc_clr <= 1'b0;
            w_last  <= 1'b0;
            w_pix   <= '0;
            ov_sr   <= '0;
            for (int i = 0; i < MAC_LAT; i++) pix_sr[i] <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                taps_q  <= cfg_taps;
                pix_q   <= cfg_pix;
                tap_idx <= '0;
                pix_idx <= '0;
            end
            // Counters return to zero after the final issue so a max-size job never wraps.
            if (issue) begin
                if (last_tap) begin
                    tap_idx <= '0;
                    pix_idx <= last_pix ? '0 : pix_idx + PIX_ONE;
                end else begin
                    tap_idx <= tap_idx + TAP_ONE;
                end
            end
            w_en    <= issue;
            acc_clr <= issue && (tap_idx == '0);
            w_last  <= issue && last_tap;
            w_pix   <= pix_idx;
            ov_sr[0]  <= w_en && w_last;
            pix_sr[0] <= w_pix;
            for (int i = 1; i < MAC_LAT; i++) begin
                ov_sr[i]  <= ov_sr[i-1];
                pix_sr[i] <= pix_sr[i-1];
            end
        end
    end

endmodule

// File: tb/tb_mac_row_seq.sv
// Directed bench for mac_row_seq: per-cycle strobe masks for each scenario, one
// instance with MAC_LAT=1 and one with MAC_LAT=3 driven from shared inputs.
module tb_mac_row_seq;

    localparam int TW = 5;
    localparam int PW = 10;

    logic          clk = 1'b0;
    logic          rst, start, in_valid;
    logic [TW-1:0] cfg_taps;
    logic [PW-1:0] cfg_pix;

    logic          rd_a, w_a, clr_a, ov_a, busy_a, done_a;
    logic [TW-1:0] tap_a;
    logic [PW-1:0] pix_a, opix_a;
    logic [1:0]    st_a;
    logic          rd_b, w_b, clr_b, ov_b, busy_b, done_b;
    logic [TW-1:0] tap_b;
    logic [PW-1:0] pix_b, opix_b;
    logic [1:0]    st_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mac_row_seq #(.TW(TW), .PW(PW), .MAC_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .cfg_taps(cfg_taps), .cfg_pix(cfg_pix),
        .in_valid(in_valid), .rd_en(rd_a), .tap_idx(tap_a), .pix_idx(pix_a),
        .w_en(w_a), .acc_clr(clr_a), .out_valid(ov_a), .out_pix(opix_a),
        .busy(busy_a), .done(done_a), .dbg_state(st_a)
    );

    mac_row_seq #(.TW(TW), .PW(PW), .MAC_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .cfg_taps(cfg_taps), .cfg_pix(cfg_pix),
        .in_valid(in_valid), .rd_en(rd_b), .tap_idx(tap_b), .pix_idx(pix_b),
        .w_en(w_b), .acc_clr(clr_b), .out_valid(ov_b), .out_pix(opix_b),
        .busy(busy_b), .done(done_b), .dbg_state(st_b)
    );

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Runs 16 cycles from a start in cycle 0 and compares every strobe against its mask.
    task automatic run_job(input bit use_b, input int taps, input int pix,
                           input logic [31:0] stall, input int start2, input int rst_c,
                           input logic [31:0] m_rd, input logic [31:0] m_w,
                           input logic [31:0] m_clr, input logic [31:0] m_ov,
                           input logic [31:0] m_done, input logic [31:0] m_busy);
        int n_iss;
        int n_ov;
        logic rd, w, clr, ov, dn, bz;
        logic [TW-1:0] ti;
        logic [PW-1:0] pi, op;
        n_iss = 0;
        n_ov  = 0;
        for (int c = 0; c < 16; c++) begin
            start    = (c == 0) || (c == start2);
            rst      = (c == rst_c);
            in_valid = !stall[c];
            cfg_taps = (c == 0) ? TW'(taps) : TW'($urandom_range(1, 31));
            cfg_pix  = (c == 0) ? PW'(pix)  : PW'($urandom_range(1, 1023));
            @(negedge clk);
            if (use_b) begin
                rd = rd_b; w = w_b; clr = clr_b; ov = ov_b; dn = done_b; bz = busy_b;
                ti = tap_b; pi = pix_b; op = opix_b;
            end else begin
                rd = rd_a; w = w_a; clr = clr_a; ov = ov_a; dn = done_a; bz = busy_a;
                ti = tap_a; pi = pix_a; op = opix_a;
            end
            chk("rd_en",     c, 32'(rd),  32'(m_rd[c]));
            chk("w_en",      c, 32'(w),   32'(m_w[c]));
            chk("acc_clr",   c, 32'(clr), 32'(m_clr[c]));
            chk("out_valid", c, 32'(ov),  32'(m_ov[c]));
            chk("done",      c, 32'(dn),  32'(m_done[c]));
            chk("busy",      c, 32'(bz),  32'(m_busy[c]));
            if (m_rd[c]) begin
                chk("tap_idx", c, 32'(ti), 32'(n_iss % taps));
                chk("pix_idx", c, 32'(pi), 32'(n_iss / taps));
                n_iss++;
            end
            if (m_ov[c]) begin
                chk("out_pix", c, 32'(op), 32'(n_ov));
                n_ov++;
            end
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        rst      = 1'b0;
        in_valid = 1'b1;
    endtask

    initial begin
        int n_rd, n_ov, done_c;
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; cfg_taps = '0; cfg_pix = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_strobes", 0, {26'b0, rd_a, w_a, clr_a, ov_a, busy_a, done_a}, 32'h0);
        chk("rst_a_idx", 0, {7'b0, tap_a, pix_a, opix_a}, 32'h0);
        chk("rst_a_state", 0, 32'(st_a), 32'h0);
        chk("rst_b_strobes", 0, {26'b0, rd_b, w_b, clr_b, ov_b, busy_b, done_b}, 32'h0);
        chk("rst_b_idx", 0, {7'b0, tap_b, pix_b, opix_b}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic job: 3 taps x 2 pixels, MAC_LAT=1.
        run_job(0, 3, 2, 32'h0, -1, -1, rng(1, 6), rng(2, 7), 32'h24,
                32'h120, 32'h200, rng(1, 9));
        // Same job with in_valid low in cycles 2-3.
        run_job(0, 3, 2, 32'hC, -1, -1, 32'h2 | rng(4, 8), 32'h4 | rng(5, 9), 32'h84,
                32'h480, 32'h800, rng(1, 11));
        // Zero pixel count, then zero tap count.
        run_job(0, 3, 0, 32'h0, -1, -1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h2, 32'h2);
        run_job(0, 0, 2, 32'h0, -1, -1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h2, 32'h2);
        // MAC_LAT=3 instance: one tap per pixel, 4 pixels.
        run_job(1, 1, 4, 32'h0, -1, -1, rng(1, 4), rng(2, 5), rng(2, 5),
                rng(5, 8), 32'h200, rng(1, 9));
        // Start pulse while busy must not disturb the job.
        run_job(0, 3, 2, 32'h0, 3, -1, rng(1, 6), rng(2, 7), 32'h24,
                32'h120, 32'h200, rng(1, 9));
        // Reset in cycle 4 abandons the job; then a fresh basic job.
        run_job(0, 3, 2, 32'h0, -1, 4, rng(1, 4), rng(2, 4), 32'h4,
                32'h0, 32'h0, rng(1, 4));
        run_job(0, 3, 2, 32'h0, -1, -1, rng(1, 6), rng(2, 7), 32'h24,
                32'h120, 32'h200, rng(1, 9));

        // Maximum configuration: 31 taps x 1023 pixels, stall-free.
        n_rd = 0; n_ov = 0; done_c = -1;
        start = 1'b1; cfg_taps = 5'd31; cfg_pix = 10'd1023;
        for (int c = 0; c < 40000 && done_c < 0; c++) begin
            @(negedge clk);
            if (rd_a) n_rd++;
            if (ov_a) begin
                chk("max_out_pix", c, 32'(opix_a), 32'(n_ov));
                n_ov++;
            end
            if (done_a) done_c = c;
            @(posedge clk);
            #1;
            start = 1'b0;
            cfg_taps = TW'($urandom_range(1, 31));
            cfg_pix  = PW'($urandom_range(1, 1023));
        end
        chk("max_done_cycle", 0, 32'(done_c), 32'(31716));
        chk("max_rd_count", 0, 32'(n_rd), 32'(31713));
        chk("max_ov_count", 0, 32'(n_ov), 32'(1023));
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_row_seq.md
# mac_row_seq

Sequencer for one `mac_row` pass in the CONV engine. It steps a tap counter inside an output-pixel counter and issues read strobes to the feature and weight buffers. It drives `w_en` and the accumulator-clear select into the six-column MAC row, and flags when the row's `co` holds finished sums for a pixel. Outer CONV control sits above it: it launches one job per output-row segment and waits for `done`.

## Interface
- `TW`, 5: tap-counter width; taps per pixel are 1..2^TW-1.
- `PW`, 10: pixel-counter width.
- `MAC_LAT`, 1: cycles from `w_en` to a valid `co` in `mac_row`; range 1..4.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  job launch pulse; sampled only in IDLE.
- `cfg_taps`  in  TW  MAC steps per output pixel; latched on accepted `start`.
- `cfg_pix`  in  PW  output pixels in this job; latched on accepted `start`.
- `in_valid`  in  1  feature and weight buffers can serve a read this cycle.
- `rd_en`  out  1  buffer read strobe (issue stage).
- `tap_idx`  out  TW  tap index of the current issue.
- `pix_idx`  out  PW  pixel index of the current issue.
- `w_en`  out  1  MAC enable to `mac_row`; `rd_en` delayed 1 cycle.
- `acc_clr`  out  1  with `w_en`; first tap of a pixel; selects zero as `ci`.
- `out_valid`  out  1  `co` holds the final sums for `out_pix`.
- `out_pix`  out  PW  pixel index of the result on `co`.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- IDLE
  - `start`=1 latches `cfg_taps` and `cfg_pix`.
  - Goes to RUN, or to DONE if either config value is 0.
- RUN
  - Each cycle with `in_valid`=1: `rd_en`=1 at the current (`pix_idx`, `tap_idx`), then the counters advance.
  - `tap_idx` wraps from `cfg_taps`-1 to 0 and increments `pix_idx`.
  - After the issue at (`cfg_pix`-1, `cfg_taps`-1), goes to DRAIN.
  - `in_valid`=0: `rd_en`=0 and the counters hold (stall bubble).
- Issue pipeline
  - A flag pair {first, last} travels with each `rd_en`.
  - `w_en`, `acc_clr`=first and the last flag are registered 1 cycle after issue.
  - `w_en`&last feeds a MAC_LAT-deep shift register. Its output is `out_valid`, and the carried pixel index is `out_pix`.
  - Consecutive pixels overlap with no gap.
  - Stall bubbles pass through as `w_en`=0 and never assert `out_valid`.
- DRAIN
  - No issues.
  - Leaves when the issue pipeline is empty, i.e. in the cycle after the final `out_valid`.
  - Goes to DONE.
- DONE
  - `done`=1 for one cycle, then IDLE.
- `busy`=1 in RUN, DRAIN and DONE.
- `start` outside IDLE is ignored; the config is not relatched.
- `rst` at any time:
  - State goes to IDLE and the pipeline is flushed.
  - All outputs return to 0 on the next edge.
  - Any job in flight is abandoned with no `done`.

## Timing
- Reset values: every output is 0; counters are 0; state is IDLE.
- `start` high in cycle 0 gives first `rd_en` in cycle 1 when `in_valid`=1.
- Every `w_en` is exactly 1 cycle after its `rd_en`.
- `out_valid` is exactly MAC_LAT cycles after the `w_en` of the pixel's last tap.
- `done` comes 1 cycle after the final `out_valid`.
- Zero config: `start` in cycle 0 gives `done`=`busy`=1 in cycle 1, with no `rd_en`, `w_en` or `out_valid`.
- Stall-free job duration: `done` at cycle `cfg_taps`*`cfg_pix` + MAC_LAT + 2.
- Each stall cycle in RUN adds exactly one cycle to the job.
- Counter wrap at maximum config (`cfg_taps`=2^TW-1, `cfg_pix`=2^PW-1) must not overflow or alias.

## Test plan
- Basic job: MAC_LAT=1, `cfg_taps`=3, `cfg_pix`=2, `in_valid`=1, `start` at cycle 0.
  - `rd_en` in cycles 1–6; `w_en` in cycles 2–7.
  - `acc_clr` at cycles 2 and 5.
  - `out_valid` at cycle 5 (`out_pix`=0) and cycle 8 (`out_pix`=1).
  - `done` at cycle 9; `busy` high in cycles 1–9.
- Stall: same job with `in_valid`=0 in cycles 2–3.
  - `rd_en` in cycles 1 and 4–8; tap 1 is issued at cycle 4.
  - `out_valid` at cycles 7 and 10; `done` at cycle 11.
- Zero config: `cfg_pix`=0 → `done` at cycle 1 and no other strobes. Repeat with `cfg_taps`=0 → same result.
- Latency parameter: MAC_LAT=3, `cfg_taps`=1, `cfg_pix`=4.
  - `w_en` in cycles 2–5, with `acc_clr` on every one.
  - `out_valid` in cycles 5–8 with `out_pix` 0..3.
  - `done` at cycle 9.
- `start` while busy: pulse `start` at cycle 3 of the basic job → identical waveform and no second job.
- Reset mid-job: assert `rst` at cycle 4 of the basic job.
  - All outputs are 0 from cycle 5; no `done`.
  - A fresh `start` then reproduces the basic-job waveform.
